// File: rtl/bellek_islem_birimi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bellek_islem_birimi_pkg : states and constants of the memory unit |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package bellek_islem_birimi_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    TAMAM = 2'd3
  } durum_t;

  localparam int unsigned c_ZAMAN_ASIMI_VARSAYILAN = 255;
  localparam int unsigned c_SAYAC_W                = 8;

  // Memory is word addressed; byte offset is carried only by the lane mask.
  function automatic logic [31:0] kelime_adresi(input logic [31:0] adr);
    return adr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bellek_islem_birimi_zaman_sayaci.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bellek_islem_birimi_zaman_sayaci : response timeout counter       |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module bellek_islem_birimi_zaman_sayaci
  import bellek_islem_birimi_pkg::*;
#(
  parameter int unsigned ZAMAN_ASIMI = c_ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_temizle,
  input  logic i_say,
  output logic o_doldu
);

  // Fires in the last counted cycle, so exactly ZAMAN_ASIMI cycles are spent waiting.
  localparam logic [c_SAYAC_W-1:0] c_SINIR = c_SAYAC_W'(ZAMAN_ASIMI - 1);

  logic [c_SAYAC_W-1:0] r_sayac;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sayac <= '0;
    end else if (i_temizle) begin
      r_sayac <= '0;
    end else if (i_say) begin
      r_sayac <= r_sayac + 1'b1;
    end
  end

  assign o_doldu = i_say && (r_sayac == c_SINIR);

endmodule
`default_nettype wire

// File: rtl/bellek_islem_birimi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bellek_islem_birimi : execute-stage data memory access unit       |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module bellek_islem_birimi
  import bellek_islem_birimi_pkg::*;
#(
  parameter int unsigned ZAMAN_ASIMI = c_ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        yrt_sec_i,
  input  logic [31:0] yrt_adr_i,
  input  logic [31:0] yrt_veri_i,
  input  logic [3:0]  yrt_maske_i,
  input  logic        ddb_durdur_i,
  output logic [31:0] yrt_veri_o,
  output logic        yrt_durdur_o,
  output logic        bel_istek_o,
  output logic        bel_yaz_o,
  output logic [31:0] bel_adr_o,
  output logic [31:0] bel_veri_o,
  output logic [3:0]  bel_maske_o,
  input  logic        bel_kabul_i,
  input  logic        bel_gecerli_i,
  input  logic [31:0] bel_veri_i,
  input  logic        bel_hata_i,
  output logic        hata_o
);

  durum_t      r_durum;
  logic [31:0] r_adr;
  logic [31:0] r_veri;
  logic [3:0]  r_maske;
  logic        r_yaz;
  logic        r_istek;
  logic [31:0] r_yrt_veri;
  logic        r_hata;

  logic        w_baslat;
  logic        w_say;
  logic        w_doldu;
  logic        w_yanit;
  logic        w_bitir;
  logic [31:0] w_bitir_veri;
  logic        w_bitir_hata;

  assign w_baslat = (r_durum == BOSTA) && yrt_sec_i;
  assign w_say    = (r_durum == ISTEK) || (r_durum == BEKLE);

  // A response only counts once the request is accepted; stray ones elsewhere are dropped.
  assign w_yanit  = bel_gecerli_i &&
                    (((r_durum == ISTEK) && bel_kabul_i) || (r_durum == BEKLE));

  // A real response takes priority over a timeout landing in the same cycle.
  assign w_bitir      = w_yanit || w_doldu;
  assign w_bitir_veri = (w_yanit && !r_yaz) ? bel_veri_i : 32'h0;
  assign w_bitir_hata = w_yanit ? bel_hata_i : 1'b1;

  bellek_islem_birimi_zaman_sayaci #(
    .ZAMAN_ASIMI (ZAMAN_ASIMI)
  ) u_zaman_sayaci (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .i_temizle (w_baslat),
    .i_say     (w_say),
    .o_doldu   (w_doldu)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_durum    <= BOSTA;
      r_adr      <= '0;
      r_veri     <= '0;
      r_maske    <= '0;
      r_yaz      <= 1'b0;
      r_istek    <= 1'b0;
      r_yrt_veri <= '0;
      r_hata     <= 1'b0;
    end else begin
      unique case (r_durum)
        BOSTA: begin
          if (yrt_sec_i) begin
            r_adr   <= yrt_adr_i;
            r_veri  <= yrt_veri_i;
            r_maske <= yrt_maske_i;
            r_yaz   <= |yrt_maske_i;
            r_istek <= 1'b1;
            r_durum <= ISTEK;
          end
        end
        ISTEK: begin
          if (w_bitir) begin
            r_istek    <= 1'b0;
            r_yrt_veri <= w_bitir_veri;
            r_hata     <= r_hata | w_bitir_hata;
            r_durum    <= TAMAM;
          end else if (bel_kabul_i) begin
            r_istek <= 1'b0;
            r_durum <= BEKLE;
          end
        end
        BEKLE: begin
          if (w_bitir) begin
            r_yrt_veri <= w_bitir_veri;
            r_hata     <= r_hata | w_bitir_hata;
            r_durum    <= TAMAM;
          end
        end
        TAMAM: begin
          if (!ddb_durdur_i) begin
            r_yrt_veri <= '0;
            r_durum    <= BOSTA;
          end
        end
        default: begin
          r_istek    <= 1'b0;
          r_yrt_veri <= '0;
          r_durum    <= BOSTA;
        end
      endcase
    end
  end

  // Idle stall is combinational so execute is held in the very cycle it asks.
  assign yrt_durdur_o = (r_durum == BOSTA) ? yrt_sec_i : (r_durum != TAMAM);
  assign yrt_veri_o   = r_yrt_veri;
  assign bel_istek_o  = r_istek;
  assign bel_yaz_o    = r_yaz;
  assign bel_adr_o    = kelime_adresi(r_adr);
  assign bel_veri_o   = r_veri;
  assign bel_maske_o  = r_maske;
  assign hata_o       = r_hata;

endmodule
`default_nettype wire

// File: tb/tb_bellek_islem_birimi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bellek_islem_birimi : directed scoreboard bench for the unit   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_bellek_islem_birimi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, yrt_sec_i, t_sec, ddb_durdur_i;
  logic [31:0] yrt_adr_i, yrt_veri_i, bel_veri_i;
  logic [3:0]  yrt_maske_i;
  logic        bel_kabul_i, bel_gecerli_i, bel_hata_i;
  logic        sifir1;
  logic [31:0] sifir32;

  logic [31:0] yrt_veri_o, bel_adr_o, bel_veri_o;
  logic        yrt_durdur_o, bel_istek_o, bel_yaz_o, hata_o;
  logic [3:0]  bel_maske_o;

  logic [31:0] t_veri, t_adr, t_bveri;
  logic        t_durdur, t_istek, t_yaz, t_hata;
  logic [3:0]  t_maske;

  bellek_islem_birimi dut (
    .clk_i(clk), .rst_i(rst_i), .yrt_sec_i(yrt_sec_i), .yrt_adr_i(yrt_adr_i),
    .yrt_veri_i(yrt_veri_i), .yrt_maske_i(yrt_maske_i), .ddb_durdur_i(ddb_durdur_i),
    .yrt_veri_o(yrt_veri_o), .yrt_durdur_o(yrt_durdur_o), .bel_istek_o(bel_istek_o),
    .bel_yaz_o(bel_yaz_o), .bel_adr_o(bel_adr_o), .bel_veri_o(bel_veri_o),
    .bel_maske_o(bel_maske_o), .bel_kabul_i(bel_kabul_i), .bel_gecerli_i(bel_gecerli_i),
    .bel_veri_i(bel_veri_i), .bel_hata_i(bel_hata_i), .hata_o(hata_o)
  );

  // Short-timeout instance whose memory never answers.
  bellek_islem_birimi #(.ZAMAN_ASIMI(4)) dut_ta (
    .clk_i(clk), .rst_i(rst_i), .yrt_sec_i(t_sec), .yrt_adr_i(yrt_adr_i),
    .yrt_veri_i(yrt_veri_i), .yrt_maske_i(yrt_maske_i), .ddb_durdur_i(ddb_durdur_i),
    .yrt_veri_o(t_veri), .yrt_durdur_o(t_durdur), .bel_istek_o(t_istek),
    .bel_yaz_o(t_yaz), .bel_adr_o(t_adr), .bel_veri_o(t_bveri),
    .bel_maske_o(t_maske), .bel_kabul_i(sifir1), .bel_gecerli_i(sifir1),
    .bel_veri_i(sifir32), .bel_hata_i(sifir1), .hata_o(t_hata)
  );

  typedef struct packed {
    logic [31:0] veri;
    logic        hata;
  } yanit_t;

  yanit_t sb[$];
  int     test_sayisi = 0;
  int     hata_sayisi = 0;
  logic   mon_onceki  = 1'b0;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    test_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: actual=%h required=%h", ad, gercek, beklenen);
    end
  endtask

  task automatic kontrol1(input string ad, input logic gercek, input logic beklenen);
    test_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: actual=%b required=%b", ad, gercek, beklenen);
    end
  endtask

  task automatic ekle(input logic [31:0] veri, input logic hata);
    yanit_t e;
    e.veri = veri;
    e.hata = hata;
    sb.push_back(e);
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic ornek();
    @(negedge clk);
  endtask

  // Monitor: a completed access shows up as the stall dropping out of ISTEK/BEKLE.
  always @(negedge clk) begin
    if (!rst_i) begin
      mon_onceki = 1'b0;
    end else begin
      if (mon_onceki && !yrt_durdur_o) begin
        if (sb.size() == 0) begin
          test_sayisi++;
          hata_sayisi++;
          $display("FAIL unexpected response: actual=%h required=none", yrt_veri_o);
        end else begin
          yanit_t e;
          e = sb.pop_front();
          kontrol("response data", yrt_veri_o, e.veri);
          kontrol1("response error flag", hata_o, e.hata);
        end
      end
      mon_onceki = yrt_durdur_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sifir1 = 1'b0; sifir32 = 32'h0;
    rst_i = 1'b0; yrt_sec_i = 1'b1; t_sec = 1'b0; ddb_durdur_i = 1'b0;
    yrt_adr_i = 32'h0; yrt_veri_i = 32'h0; yrt_maske_i = 4'h0;
    bel_kabul_i = 1'b0; bel_gecerli_i = 1'b0; bel_hata_i = 1'b0; bel_veri_i = 32'h0;

    // Reset state
    repeat (2) adim();
    ornek();
    kontrol1("reset bel_istek", bel_istek_o, 1'b0);
    kontrol("reset yrt_veri", yrt_veri_o, 32'h0);
    kontrol1("reset hata", hata_o, 1'b0);
    kontrol1("reset stall follows sel=1", yrt_durdur_o, 1'b1);
    adim(); yrt_sec_i = 1'b0;
    ornek();
    kontrol1("reset stall follows sel=0", yrt_durdur_o, 1'b0);
    adim(); rst_i = 1'b1;
    adim();

    // Load, accept and respond in the ISTEK cycle
    yrt_sec_i = 1'b1; yrt_adr_i = 32'h0000_1006; yrt_veri_i = 32'h5555_AAAA; yrt_maske_i = 4'h0;
    ekle(32'hDEAD_BEEF, 1'b0);
    ornek();
    kontrol1("load stall cycle 1", yrt_durdur_o, 1'b1);
    kontrol1("load no request in BOSTA", bel_istek_o, 1'b0);
    adim(); yrt_sec_i = 1'b0; bel_kabul_i = 1'b1; bel_gecerli_i = 1'b1; bel_veri_i = 32'hDEAD_BEEF;
    ornek();
    kontrol1("load request", bel_istek_o, 1'b1);
    kontrol("load word address", bel_adr_o, 32'h0000_1004);
    kontrol1("load write flag", bel_yaz_o, 1'b0);
    kontrol1("load stall cycle 2", yrt_durdur_o, 1'b1);
    adim(); bel_kabul_i = 1'b0; bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
    ornek();
    kontrol1("load request dropped", bel_istek_o, 1'b0);
    adim();
    ornek();
    kontrol("load data cleared after TAMAM", yrt_veri_o, 32'h0);

    // Store, accept on third ISTEK cycle, respond two cycles later
    adim(); yrt_sec_i = 1'b1; yrt_adr_i = 32'h0000_2002; yrt_veri_i = 32'h1234_5678; yrt_maske_i = 4'b0011;
    ekle(32'h0, 1'b0);
    adim(); yrt_sec_i = 1'b0; yrt_adr_i = 32'hFFFF_FFFF; yrt_veri_i = 32'h0; yrt_maske_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      bel_kabul_i = (i == 2);
      ornek();
      kontrol1("store request held", bel_istek_o, 1'b1);
      kontrol("store address stable", bel_adr_o, 32'h0000_2000);
      kontrol("store data stable", bel_veri_o, 32'h1234_5678);
      kontrol("store mask stable", {28'h0, bel_maske_o}, 32'h3);
      kontrol1("store write flag", bel_yaz_o, 1'b1);
      adim();
    end
    bel_kabul_i = 1'b0;
    ornek();
    kontrol1("store BEKLE no request", bel_istek_o, 1'b0);
    kontrol1("store BEKLE stall", yrt_durdur_o, 1'b1);
    adim(); bel_gecerli_i = 1'b1; bel_veri_i = 32'hFFFF_FFFF;
    ornek();
    kontrol1("store BEKLE stall 2", yrt_durdur_o, 1'b1);
    adim(); bel_gecerli_i = 1'b0; bel_veri_i = 32'h0;
    ornek();
    adim();

    // Load with error response
    yrt_sec_i = 1'b1; yrt_adr_i = 32'h0000_0044; yrt_maske_i = 4'h0;
    ekle(32'h0BAD_0BAD, 1'b1);
    adim(); yrt_sec_i = 1'b0; bel_kabul_i = 1'b1; bel_gecerli_i = 1'b1; bel_hata_i = 1'b1; bel_veri_i = 32'h0BAD_0BAD;
    adim(); bel_kabul_i = 1'b0; bel_gecerli_i = 1'b0; bel_hata_i = 1'b0; bel_veri_i = 32'h0;
    ornek();
    adim();

    // Load held in TAMAM by downstream stall; stray response there is ignored
    yrt_sec_i = 1'b1; yrt_adr_i = 32'h0000_0030;
    ekle(32'hCAFE_F00D, 1'b1);
    adim(); yrt_sec_i = 1'b0; bel_kabul_i = 1'b1;
    adim(); bel_kabul_i = 1'b0; bel_gecerli_i = 1'b1; bel_veri_i = 32'hCAFE_F00D; ddb_durdur_i = 1'b1;
    adim();
    for (int i = 0; i < 4; i++) begin
      ddb_durdur_i  = (i < 3);
      bel_gecerli_i = (i == 1);
      bel_veri_i    = (i == 1) ? 32'h1111_1111 : 32'h0;
      ornek();
      kontrol1("TAMAM hold no reissue", bel_istek_o, 1'b0);
      kontrol("TAMAM hold data", yrt_veri_o, 32'hCAFE_F00D);
      kontrol1("TAMAM hold no stall", yrt_durdur_o, 1'b0);
      kontrol1("sticky error kept", hata_o, 1'b1);
      adim();
    end
    ddb_durdur_i = 1'b0; bel_gecerli_i = 1'b0;
    ornek();
    kontrol("back to BOSTA data", yrt_veri_o, 32'h0);
    kontrol1("back to BOSTA no request", bel_istek_o, 1'b0);

    // Timeout on the short-limit instance
    adim(); t_sec = 1'b1; yrt_adr_i = 32'h0000_0050;
    ornek();
    kontrol1("timeout stall in BOSTA", t_durdur, 1'b1);
    adim(); t_sec = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ornek();
      kontrol1("timeout waiting request", t_istek, 1'b1);
      kontrol1("timeout waiting stall", t_durdur, 1'b1);
      kontrol1("timeout waiting no error", t_hata, 1'b0);
      adim();
    end
    ornek();
    kontrol1("timeout TAMAM no stall", t_durdur, 1'b0);
    kontrol("timeout TAMAM data", t_veri, 32'h0);
    kontrol1("timeout error set", t_hata, 1'b1);
    adim(); adim();
    ornek();
    kontrol1("timeout error held", t_hata, 1'b1);
    kontrol1("timeout no reissue", t_istek, 1'b0);

    // Reset while waiting in BEKLE, then a late response
    adim(); yrt_sec_i = 1'b1; yrt_adr_i = 32'h0000_0060;
    adim(); yrt_sec_i = 1'b0; bel_kabul_i = 1'b1;
    adim(); bel_kabul_i = 1'b0;
    ornek();
    kontrol1("BEKLE before reset stall", yrt_durdur_o, 1'b1);
    adim(); rst_i = 1'b0;
    adim(); rst_i = 1'b1; bel_gecerli_i = 1'b1; bel_hata_i = 1'b1; bel_veri_i = 32'h7777_7777;
    ornek();
    kontrol1("reset abandon request", bel_istek_o, 1'b0);
    kontrol1("reset abandon error cleared", hata_o, 1'b0);
    kontrol1("reset clears timeout error", t_hata, 1'b0);
    kontrol("reset abandon data", yrt_veri_o, 32'h0);
    kontrol1("reset abandon no stall", yrt_durdur_o, 1'b0);
    adim(); bel_gecerli_i = 1'b0; bel_hata_i = 1'b0; bel_veri_i = 32'h0;
    ornek();
    kontrol1("late response ignored error", hata_o, 1'b0);
    kontrol("late response ignored data", yrt_veri_o, 32'h0);

    adim(); adim();
    kontrol("scoreboard drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bellek_islem_birimi.md
BELLEK_ISLEM_BIRIMI -- requirements
Module: bellek_islem_birimi

Interface
REQ-001 Parameter ZAMAN_ASIMI, default 255, response-timeout limit in cycles (1..255).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-low reset.
REQ-004 yrt_sec_i  in  1  execute stage requests a memory access.
REQ-005 yrt_adr_i  in  32  byte address from execute.
REQ-006 yrt_veri_i  in  32  store data from execute.
REQ-007 yrt_maske_i  in  4  byte-lane mask; 4'b0000 = load, non-zero = store of the marked lanes.
REQ-008 ddb_durdur_i  in  1  pipeline stall from the control unit, excluding this unit's own stall.
REQ-009 yrt_veri_o  out  32  load data returned to execute.
REQ-010 yrt_durdur_o  out  1  holds execute while an access is outstanding.
REQ-011 bel_istek_o  out  1  request valid to data memory.
REQ-012 bel_yaz_o  out  1  1 = write, 0 = read.
REQ-013 bel_adr_o  out  32  word-aligned address.
REQ-014 bel_veri_o  out  32  write data.
REQ-015 bel_maske_o  out  4  write byte mask.
REQ-016 bel_kabul_i  in  1  memory accepts the request.
REQ-017 bel_gecerli_i  in  1  response valid, for both reads and writes.
REQ-018 bel_veri_i  in  32  read data, valid with bel_gecerli_i.
REQ-019 bel_hata_i  in  1  error response, valid with bel_gecerli_i.
REQ-020 hata_o  out  1  sticky error/timeout flag.

Function
REQ-021 FSM states: BOSTA, ISTEK, BEKLE, TAMAM.
REQ-022 BOSTA: on yrt_sec_i=1, register adr, veri, maske and go to ISTEK; yrt_durdur_o = yrt_sec_i combinationally.
REQ-023 ISTEK: bel_istek_o=1 with registered fields; yrt_durdur_o=1; bel_kabul_i=1 moves to BEKLE, or to TAMAM if bel_gecerli_i=1 in the same cycle.
REQ-024 BEKLE: bel_istek_o=0, yrt_durdur_o=1; bel_gecerli_i=1 moves to TAMAM.
REQ-025 TAMAM: yrt_durdur_o=0; yrt_veri_o = latched data; ddb_durdur_i=0 moves to BOSTA, otherwise stay, with no re-issue of the access.
REQ-026 Outside TAMAM, yrt_veri_o=0.
REQ-027 Field mapping: bel_adr_o = {adr[31:2],2'b00}; bel_yaz_o = (maske != 0); bel_maske_o = registered maske; bel_veri_o = registered veri.
REQ-028 Response latch: reads latch bel_veri_i; writes latch 32'h0.
REQ-029 Request fields hold stable while bel_istek_o=1 and bel_kabul_i=0.
REQ-030 Timeout counter (8 bit): cleared on entering ISTEK; increments each cycle in ISTEK or BEKLE.
REQ-031 On reaching ZAMAN_ASIMI without bel_gecerli_i: go to TAMAM with latched data 0 and set hata_o.
REQ-032 hata_o is also set by bel_gecerli_i & bel_hata_i, and is cleared only by reset.
REQ-033 Minimum load latency: 2 stalled cycles (BOSTA, ISTEK), then data in TAMAM.
REQ-034 A bel_gecerli_i arriving in BOSTA or TAMAM is ignored.

Reset
REQ-035 rst_i=0 at a clock edge: state=BOSTA, counter=0, latches=0, hata_o=0.
REQ-036 During and after reset: bel_istek_o=0, yrt_veri_o=0; yrt_durdur_o follows REQ-022.
REQ-037 Reset mid-access abandons the access; a late response is ignored per REQ-034.

Structure
REQ-038 State encodings and the ZAMAN_ASIMI default live in tanimlamalar.vh.
REQ-039 Optional sub-module bib_zaman_sayaci implements the timeout counter; all other logic is flat.

Verification
REQ-040 Load at 0x0000_1006, mask 0; kabul and gecerli in the ISTEK cycle with data 0xDEAD_BEEF -> bel_adr_o=0x0000_1004, bel_yaz_o=0, stall for 2 cycles, then yrt_veri_o=0xDEAD_BEEF.
REQ-041 Store 0x1234_5678 with mask 4'b0011; kabul after 3 cycles, gecerli 2 cycles later -> bel_maske_o=0011, bel_yaz_o=1, fields stable throughout, yrt_veri_o=0 in TAMAM.
REQ-042 ZAMAN_ASIMI=4, memory never responds -> TAMAM after 4 counted cycles, yrt_veri_o=0, hata_o=1 and held.
REQ-043 ddb_durdur_i=1 for 3 cycles in TAMAM -> bel_istek_o stays 0 (single request), data held; BOSTA the cycle after ddb_durdur_i falls.
REQ-044 rst_i=0 asserted in BEKLE, then gecerli arrives -> state BOSTA, bel_istek_o=0, hata_o=0, response ignored.
